md4_padder: RTL and testbench

MD4_PADDER -- requirements
Module: md4_padder

---
 rtl/md4_padder.sv | 123 ++++++++++++
 tb/tb_md4_padder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md4_padder.sv
// MD4 message padder: packs a byte stream into 512-bit blocks and appends 0x80, zero fill and the 64-bit bit length.
// Optional sticky length-overflow flag LEN_OVF is enabled by defining MD4_PADDER_OVF_EN.
module md4_padder #(
  parameter int LEN_W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [7:0]   IN_DATA,
  input  logic         IN_VALID,
  input  logic         IN_LAST,
  input  logic         IN_KEEP,
  output logic         IN_READY,
  output logic [511:0] BLK_DATA,
  output logic         BLK_VALID,
  output logic         BLK_LAST,
  input  logic         BLK_READY
`ifdef MD4_PADDER_OVF_EN
  ,
  output logic         LEN_OVF
`endif
);

  typedef enum logic [2:0] {FILL, EMIT, PAD, EMIT_P, EMIT_LAST} state_t;

  state_t           r_state;
  logic [511:0]     r_buf;
  logic [5:0]       r_ptr;
  logic [LEN_W-1:0] r_count;
  logic             r_pend;
  logic             r_valid;
  logic             r_last;

  logic [63:0]      w_len;
  logic [8:0]       w_bidx;

  assign w_len     = 64'({r_count, 3'b000});
  assign w_bidx    = {r_ptr, 3'b000};
  assign IN_READY  = (r_state == FILL);
  assign BLK_DATA  = r_buf;
  assign BLK_VALID = r_valid;
  assign BLK_LAST  = r_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= FILL;
      r_buf   <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        FILL: if (IN_VALID) begin
          if (IN_KEEP) begin
            r_buf[w_bidx +: 8] <= IN_DATA;
            r_ptr              <= r_ptr + 6'd1;
            r_count            <= r_count + {{(LEN_W-1){1'b0}}, 1'b1};
          end
          // 64th byte closes the block even if it is also the last byte
          if (IN_KEEP && (r_ptr == 6'd63)) begin
            r_state <= EMIT;
            r_pend  <= IN_LAST;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
          end else if (IN_LAST) begin
            r_state <= PAD;
          end
        end
        EMIT: if (BLK_READY) begin
          r_buf   <= '0;
          r_valid <= 1'b0;
          r_state <= r_pend ? PAD : FILL;
        end
        PAD: begin
          for (int i = 0; i < 64; i++)
            if (6'(i) > r_ptr) r_buf[8*i +: 8] <= 8'h00;
          r_buf[w_bidx +: 8] <= 8'h80;
          r_valid <= 1'b1;
          // length only fits behind the 0x80 marker when bytes 56..63 are still free
          if (r_ptr <= 6'd55) begin
            r_buf[511:448] <= w_len;
            r_last         <= 1'b1;
            r_state        <= EMIT_LAST;
          end else begin
            r_last  <= 1'b0;
            r_state <= EMIT_P;
          end
        end
        EMIT_P: if (BLK_READY) begin
          r_buf   <= {w_len, 448'd0};
          r_last  <= 1'b1;
          r_state <= EMIT_LAST;
        end
        EMIT_LAST: if (BLK_READY) begin
          r_buf   <= '0;
          r_ptr   <= '0;
          r_count <= '0;
          r_pend  <= 1'b0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_state <= FILL;
        end
        default: r_state <= FILL;
      endcase
    end
  end

`ifdef MD4_PADDER_OVF_EN
  logic r_ovf;
  assign LEN_OVF = r_ovf;

  always_ff @(posedge CLK) begin
    if (RST)
      r_ovf <= 1'b0;
    else if ((r_state == EMIT_LAST) && BLK_READY)
      r_ovf <= 1'b0;
    else if ((r_state == FILL) && IN_VALID && IN_KEEP && (&r_count))
      r_ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_md4_padder.sv
// Self-checking bench for md4_padder: directed vectors plus random messages against a standard MD4 padding model.
module tb_md4_padder;
`ifdef MD4_PADDER_OVF_EN
  localparam int LW = 4;
`else
  localparam int LW = 32;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [7:0]   IN_DATA = '0;
  logic         IN_VALID = 1'b0;
  logic         IN_LAST = 1'b0;
  logic         IN_KEEP = 1'b0;
  logic         IN_READY;
  logic [511:0] BLK_DATA;
  logic         BLK_VALID;
  logic         BLK_LAST;
  logic         BLK_READY = 1'b0;
`ifdef MD4_PADDER_OVF_EN
  logic         LEN_OVF;
`endif

  md4_padder #(.LEN_W(LW)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .IN_KEEP(IN_KEEP), .IN_READY(IN_READY), .BLK_DATA(BLK_DATA), .BLK_VALID(BLK_VALID),
    .BLK_LAST(BLK_LAST), .BLK_READY(BLK_READY)
`ifdef MD4_PADDER_OVF_EN
    , .LEN_OVF(LEN_OVF)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  byte unsigned msg_q[$];
  logic [511:0] exp_q[$];
  logic [511:0] got_d[$];
  logic         got_l[$];

  // Reference: message || 0x80 || zeros to 56 mod 64 || 64-bit LE bit length (count wraps at LW bits)
  task automatic model();
    byte unsigned p[$];
    logic [63:0]  len;
    logic [511:0] b;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = (64'(msg_q.size()) % (64'd1 << LW)) << 3;
    for (int i = 0; i < 8; i++) p.push_back(len[8*i +: 8]);
    exp_q.delete();
    for (int k = 0; k < p.size() / 64; k++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b[8*j +: 8] = p[64*k + j];
      exp_q.push_back(b);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic drive_beat(input logic [7:0] d, input logic k, input logic l);
    int n;
    n = 0;
    IN_VALID = 1'b1; IN_DATA = d; IN_KEEP = k; IN_LAST = l;
    while (IN_READY !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL beat_timeout: IN_READY=%b after %0d cycles, required 1", IN_READY, n);
    end
    @(negedge CLK);
    IN_VALID = 1'b0; IN_KEEP = 1'b0; IN_LAST = 1'b0;
  endtask

  task automatic send_msg(input bit term);
    for (int i = 0; i < msg_q.size(); i++) begin
      if ($urandom_range(3) == 0) @(negedge CLK);
      if ($urandom_range(4) == 0) drive_beat(8'($urandom), 1'b0, 1'b0);
      drive_beat(msg_q[i], 1'b1, (i == msg_q.size() - 1) && !term);
    end
    if (msg_q.size() == 0 || term) drive_beat(8'($urandom), 1'b0, 1'b1);
  endtask

  // Accepts n blocks with random BLK_READY, watching that a stalled block holds still.
  task automatic collect(input int n, input int rdy_pct);
    logic [511:0] pd;
    logic pl;
    bit hold;
    int cyc;
    hold = 0; cyc = 0; pd = '0; pl = 0;
    got_d.delete(); got_l.delete();
    while (got_d.size() < n && cyc < 5000) begin
      if (hold) begin
        checks++;
        if (BLK_VALID !== 1'b1 || BLK_DATA !== pd || BLK_LAST !== pl) begin
          failures++;
          $display("FAIL hold_stable: valid=%b last=%b data=%h, required valid=1 last=%b data=%h",
                   BLK_VALID, BLK_LAST, BLK_DATA, pl, pd);
        end
      end
      BLK_READY = ($urandom_range(99) < rdy_pct);
      if (BLK_VALID === 1'b1 && BLK_READY) begin
        got_d.push_back(BLK_DATA);
        got_l.push_back(BLK_LAST);
      end
      hold = (BLK_VALID === 1'b1) && !BLK_READY;
      pd = BLK_DATA; pl = BLK_LAST;
      @(negedge CLK); cyc++;
    end
    BLK_READY = 1'b0;
    if (got_d.size() < n) begin
      checks++; failures++;
      $display("FAIL collect_timeout: got %0d blocks, required %0d", got_d.size(), n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks += 4;
    if (IN_READY !== 1'b1) begin failures++; $display("FAIL rst_in_ready: %b, required 1", IN_READY); end
    if (BLK_VALID !== 1'b0) begin failures++; $display("FAIL rst_blk_valid: %b, required 0", BLK_VALID); end
    if (BLK_LAST !== 1'b0) begin failures++; $display("FAIL rst_blk_last: %b, required 0", BLK_LAST); end
    if (BLK_DATA !== 512'd0) begin failures++; $display("FAIL rst_blk_data: %h, required 0", BLK_DATA); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_spec_vectors();
    logic [511:0] e[2];
    int nb;
    for (int v = 0; v < 4; v++) begin
      msg_q.delete();
      e[0] = '0; e[1] = '0;
      case (v)
        0: begin msg_q = '{8'h61, 8'h62}; e[0][31:0] = 32'h00806261; e[0][14*32 +: 32] = 32'h10; nb = 1; end
        1: begin e[0][31:0] = 32'h00000080; nb = 1; end
        2: begin
          for (int i = 0; i < 56; i++) begin msg_q.push_back(8'($urandom)); e[0][8*i +: 8] = msg_q[i]; end
          e[0][8*56 +: 8] = 8'h80;
          e[1][14*32 +: 32] = (LW == 32) ? 32'h1C0 : 32'((64'd56 % (64'd1 << LW)) * 8);
          nb = 2;
        end
        default: begin
          for (int i = 0; i < 64; i++) begin msg_q.push_back(8'($urandom)); e[0][8*i +: 8] = msg_q[i]; end
          e[1][31:0] = 32'h00000080;
          e[1][14*32 +: 32] = (LW == 32) ? 32'h200 : 32'((64'd64 % (64'd1 << LW)) * 8);
          nb = 2;
        end
      endcase
      fork
        send_msg(1'b0);
        collect(nb, 60);
      join
      checks++;
      if (got_d.size() != nb) begin
        failures++; $display("FAIL vec%0d_count: %0d blocks, required %0d", v, got_d.size(), nb);
      end else begin
        for (int b = 0; b < nb; b++) begin
          checks += 2;
          if (got_d[b] !== e[b]) begin
            failures++; $display("FAIL vec%0d_blk%0d_data: %h, required %h", v, b, got_d[b], e[b]);
          end
          if (got_l[b] !== (b == nb - 1)) begin
            failures++; $display("FAIL vec%0d_blk%0d_last: %b, required %b", v, b, got_l[b], b == nb - 1);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int len;
    bit term;
    for (int m = 0; m < 8; m++) begin
      len = $urandom_range(140);
      term = $urandom_range(1);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      model();
      fork
        send_msg(term);
        collect(exp_q.size(), 50);
      join
      checks++;
      if (got_d.size() != exp_q.size()) begin
        failures++; $display("FAIL rnd%0d_count: %0d blocks, required %0d (len=%0d)", m, got_d.size(), exp_q.size(), len);
      end else begin
        for (int b = 0; b < exp_q.size(); b++) begin
          checks += 2;
          if (got_d[b] !== exp_q[b]) begin
            failures++; $display("FAIL rnd%0d_blk%0d_data: %h, required %h", m, b, got_d[b], exp_q[b]);
          end
          if (got_l[b] !== (b == exp_q.size() - 1)) begin
            failures++; $display("FAIL rnd%0d_blk%0d_last: %b, required %b", m, b, got_l[b], b == exp_q.size() - 1);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    msg_q = '{8'h11, 8'h22, 8'h33};
    model();
    send_msg(1'b0);
    n = 0;
    while (BLK_VALID !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    for (int c = 0; c < 5; c++) begin
      checks += 3;
      if (BLK_VALID !== 1'b1) begin failures++; $display("FAIL bp_valid c%0d: %b, required 1", c, BLK_VALID); end
      if (IN_READY !== 1'b0) begin failures++; $display("FAIL bp_in_ready c%0d: %b, required 0", c, IN_READY); end
      if (BLK_DATA !== exp_q[0]) begin failures++; $display("FAIL bp_data c%0d: %h, required %h", c, BLK_DATA, exp_q[0]); end
      @(negedge CLK);
    end
    BLK_READY = 1'b1;
    @(negedge CLK);
    BLK_READY = 1'b0;
    checks += 2;
    if (BLK_VALID !== 1'b0) begin failures++; $display("FAIL bp_drain_valid: %b, required 0", BLK_VALID); end
    if (IN_READY !== 1'b1) begin failures++; $display("FAIL bp_drain_ready: %b, required 1", IN_READY); end
  endtask

  task automatic test_latency();
    drive_beat(8'h55, 1'b1, 1'b1);
    checks += 3;
    if (BLK_VALID !== 1'b0) begin failures++; $display("FAIL lat_last_t1: valid=%b, required 0", BLK_VALID); end
    @(negedge CLK);
    if (BLK_VALID !== 1'b1) begin failures++; $display("FAIL lat_last_t2: valid=%b, required 1", BLK_VALID); end
    if (BLK_LAST !== 1'b1) begin failures++; $display("FAIL lat_last_flag: last=%b, required 1", BLK_LAST); end
    collect(1, 100);
    for (int i = 0; i < 64; i++) drive_beat(8'(i), 1'b1, 1'b0);
    checks += 2;
    if (BLK_VALID !== 1'b1) begin failures++; $display("FAIL lat_full_t1: valid=%b, required 1", BLK_VALID); end
    if (BLK_LAST !== 1'b0) begin failures++; $display("FAIL lat_full_last: last=%b, required 0", BLK_LAST); end
    fork
      drive_beat(8'hA5, 1'b0, 1'b1);
      collect(2, 100);
    join
    checks++;
    if (got_l.size() != 2 || got_l[1] !== 1'b1 || got_d[1][31:0] !== 32'h80) begin
      failures++; $display("FAIL lat_term_block: count=%0d, required 2 blocks ending with 0x80 marker", got_l.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] e;
    for (int i = 0; i < 10; i++) drive_beat(8'hEE, 1'b1, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks += 2;
    if (BLK_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      failures++; $display("FAIL rstmid_ctrl: valid=%b ready=%b, required 0/1", BLK_VALID, IN_READY);
    end
    if (BLK_DATA !== 512'd0) begin failures++; $display("FAIL rstmid_data: %h, required 0", BLK_DATA); end
    msg_q = '{8'h61, 8'h62};
    e = '0; e[31:0] = 32'h00806261; e[14*32 +: 32] = 32'h10;
    fork
      send_msg(1'b0);
      collect(1, 70);
    join
    checks++;
    if (got_d.size() != 1 || got_d[0] !== e || got_l[0] !== 1'b1) begin
      failures++; $display("FAIL rstmid_block: %h, required %h", (got_d.size() > 0) ? got_d[0] : 512'd0, e);
    end
  endtask

`ifdef MD4_PADDER_OVF_EN
  task automatic test_ovf();
    msg_q.delete();
    for (int i = 0; i < 17; i++) msg_q.push_back(8'(i + 1));
    model();
    for (int i = 0; i < 15; i++) drive_beat(msg_q[i], 1'b1, 1'b0);
    checks++;
    if (LEN_OVF !== 1'b0) begin failures++; $display("FAIL ovf_pre: %b, required 0", LEN_OVF); end
    drive_beat(msg_q[15], 1'b1, 1'b0);
    checks++;
    if (LEN_OVF !== 1'b1) begin failures++; $display("FAIL ovf_set: %b, required 1", LEN_OVF); end
    fork
      drive_beat(msg_q[16], 1'b1, 1'b1);
      collect(1, 60);
    join
    checks += 3;
    if (got_d.size() != 1 || got_d[0] !== exp_q[0]) begin
      failures++; $display("FAIL ovf_block: %h, required %h", (got_d.size() > 0) ? got_d[0] : 512'd0, exp_q[0]);
    end
    if (got_d.size() == 1 && got_d[0][14*32 +: 32] !== 32'h08) begin
      failures++; $display("FAIL ovf_len: %h, required 00000008", got_d[0][14*32 +: 32]);
    end
    if (LEN_OVF !== 1'b0) begin failures++; $display("FAIL ovf_clear: %b, required 0", LEN_OVF); end
  endtask
`endif

  initial begin
    test_reset();
    test_spec_vectors();
    test_latency();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef MD4_PADDER_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
